// File: rtl/wb_regfile.sv
// Write-back stage fused with the 32x32 GPR file: write-back select, commit,
// two ID read ports with same-cycle write-through bypass, and a retired-instruction counter.
module wb_regfile #(
  parameter logic [31:0] SP_INIT = 32'h0000_2ffc,
  parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regWrite,
  input  logic [1:0]  memToReg,
  input  logic [4:0]  writeDataReg,
  input  logic [31:0] aluResult,
  input  logic [31:0] readData,
  input  logic [29:0] fourPC,
  input  logic [31:0] instruction,
  input  logic [4:0]  readReg1,
  input  logic [4:0]  readReg2,
  output logic [31:0] readData1,
  output logic [31:0] readData2,
  output logic [31:0] wbData,
  output logic [31:0] retireCount,
  input  logic [4:0]  dbgReg,
  output logic [31:0] dbgData
);

  // $0 has no storage; index 0 is never addressed in the array
  logic [31:0] regs_r [1:31];
  logic [31:0] retire_count_r;
  logic [31:0] wb_data_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic [31:0] dbg_s;
  logic        commit_s;

  // Write-back source select; the reserved encoding falls back to the ALU result
  always_comb begin
    wb_data_s = 32'h0000_0000;
    case (memToReg)
      2'b00:   wb_data_s = aluResult;
      2'b01:   wb_data_s = readData;
      2'b10:   wb_data_s = {fourPC, 2'b00};
      default: wb_data_s = aluResult;
    endcase
  end

  // Commit qualifier; reset suppresses both the write and the bypass
  always_comb begin
    commit_s = regWrite && (writeDataReg != 5'd0) && !rst;
  end

  // Read port 1 with write-through bypass
  always_comb begin
    rd1_s = 32'h0000_0000;
    if (readReg1 == 5'd0) begin
      rd1_s = 32'h0000_0000;
    end else if (commit_s && (writeDataReg == readReg1)) begin
      rd1_s = wb_data_s;
    end else begin
      rd1_s = regs_r[readReg1];
    end
  end

  // Read port 2 with write-through bypass
  always_comb begin
    rd2_s = 32'h0000_0000;
    if (readReg2 == 5'd0) begin
      rd2_s = 32'h0000_0000;
    end else if (commit_s && (writeDataReg == readReg2)) begin
      rd2_s = wb_data_s;
    end else begin
      rd2_s = regs_r[readReg2];
    end
  end

  // Debug port shows committed state only
  always_comb begin
    dbg_s = 32'h0000_0000;
    if (dbgReg == 5'd0) begin
      dbg_s = 32'h0000_0000;
    end else begin
      dbg_s = regs_r[dbgReg];
    end
  end

  // Register array: reset image, then commits
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) begin
        regs_r[i] <= 32'h0000_0000;
      end
      regs_r[28] <= GP_INIT;
      regs_r[29] <= SP_INIT;
    end else if (commit_s) begin
      regs_r[writeDataReg] <= wb_data_s;
    end
  end

  // Retired-instruction counter; NOP words do not count, wraps silently
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_count_r <= 32'h0000_0000;
    end else if (instruction != 32'h0000_0000) begin
      retire_count_r <= retire_count_r + 32'h0000_0001;
    end
  end

  assign wbData      = wb_data_s;
  assign readData1   = rd1_s;
  assign readData2   = rd2_s;
  assign dbgData     = dbg_s;
  assign retireCount = retire_count_r;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        regWrite;
  logic [1:0]  memToReg;
  logic [4:0]  writeDataReg;
  logic [31:0] aluResult;
  logic [31:0] readData;
  logic [29:0] fourPC;
  logic [31:0] instruction;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] wbData;
  logic [31:0] retireCount;
  logic [4:0]  dbgReg;
  logic [31:0] dbgData;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_regs [0:31];
  logic [31:0] m_cnt;

  wb_regfile dut (
    .clk(clk), .rst(rst), .regWrite(regWrite), .memToReg(memToReg),
    .writeDataReg(writeDataReg), .aluResult(aluResult), .readData(readData),
    .fourPC(fourPC), .instruction(instruction), .readReg1(readReg1),
    .readReg2(readReg2), .readData1(readData1), .readData2(readData2),
    .wbData(wbData), .retireCount(retireCount), .dbgReg(dbgReg), .dbgData(dbgData)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_wb();
    logic [31:0] v;
    if (memToReg == 2'b01)      v = readData;
    else if (memToReg == 2'b10) v = {fourPC, 2'b00};
    else                        v = aluResult;
    return v;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) v = 32'h0;
    else if (!rst && regWrite && writeDataReg != 5'd0 && writeDataReg == a) v = exp_wb();
    else v = m_regs[a];
    return v;
  endfunction

  // Compare every output before the edge, then advance the model across it
  task automatic cycle();
    #1;
    check("wbData", wbData, exp_wb());
    check("readData1", readData1, exp_read(readReg1));
    check("readData2", readData2, exp_read(readReg2));
    check("dbgData", dbgData, (dbgReg == 5'd0) ? 32'h0 : m_regs[dbgReg]);
    check("retireCount", retireCount, m_cnt);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_regs[28] = 32'h0000_1800;
      m_regs[29] = 32'h0000_2ffc;
      m_cnt = 32'h0;
    end else begin
      if (regWrite && writeDataReg != 5'd0) m_regs[writeDataReg] = exp_wb();
      if (instruction != 32'h0) m_cnt = m_cnt + 32'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    regWrite = 1'b0; memToReg = 2'b00; writeDataReg = 5'd0;
    aluResult = 32'h0; readData = 32'h0; fourPC = 30'h0; instruction = 32'h0;
    readReg1 = 5'd0; readReg2 = 5'd0; dbgReg = 5'd0;
  endtask

  task automatic wr(input logic [4:0] r, input logic [1:0] src, input logic [31:0] v);
    regWrite = 1'b1; writeDataReg = r; memToReg = src;
    aluResult = v; readData = v; fourPC = v[29:0];
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 32'h0;
    idle();
    rst = 1'b1;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;

    // Reset values
    readReg1 = 5'd29; #1 check("rst_sp", readData1, 32'h0000_2ffc);
    readReg1 = 5'd28; #1 check("rst_gp", readData1, 32'h0000_1800);
    readReg1 = 5'd5;  #1 check("rst_r5", readData1, 32'h0);
    check("rst_cnt", retireCount, 32'h0);
    #1;

    // Write-back mux and commit
    wr(5'd8, 2'b00, 32'h1234_5678); readData = 32'h5555_5555; cycle();
    idle(); dbgReg = 5'd8; #1 check("mux_alu", dbgData, 32'h1234_5678);
    wr(5'd9, 2'b01, 32'hdead_beef); aluResult = 32'h0; cycle();
    idle(); dbgReg = 5'd9; #1 check("mux_load", dbgData, 32'hdead_beef);
    wr(5'd31, 2'b10, 32'h0); fourPC = 30'h0000_0c01; aluResult = 32'h7; cycle();
    idle(); dbgReg = 5'd31; #1 check("mux_link", dbgData, 32'h0000_3004);
    wr(5'd7, 2'b11, 32'h0); aluResult = 32'h0bad_f00d; readData = 32'h1; cycle();
    idle(); dbgReg = 5'd7; #1 check("mux_rsvd", dbgData, 32'h0bad_f00d);

    // $0 protection
    wr(5'd0, 2'b00, 32'hffff_ffff); readReg1 = 5'd0; dbgReg = 5'd0;
    #1 check("r0_same", readData1, 32'h0);
    cycle();
    idle(); #1 check("r0_after", readData1, 32'h0); check("r0_dbg", dbgData, 32'h0);

    // Bypass
    wr(5'd10, 2'b00, 32'h11); cycle();
    wr(5'd10, 2'b00, 32'h22); readReg1 = 5'd10; readReg2 = 5'd10; dbgReg = 5'd10;
    #1 check("byp_rd1", readData1, 32'h22); check("byp_rd2", readData2, 32'h22);
    check("byp_dbg_pre", dbgData, 32'h11);
    cycle();
    idle(); dbgReg = 5'd10; #1 check("byp_dbg_post", dbgData, 32'h22);

    // Retire counter: 5 real instructions, 2 NOPs
    for (int i = 0; i < 7; i++) begin
      instruction = (i < 5) ? 32'h2000_0000 + 32'(i) + 32'd1 : 32'h0;
      cycle();
    end
    idle(); #1 check("retire5", retireCount, 32'd5);

    // Counter wrap from a forced near-wrap state
    force dut.retire_count_r = 32'hffff_fffe;
    #1 release dut.retire_count_r;
    m_cnt = 32'hffff_fffe;
    instruction = 32'h0000_0020; cycle();
    idle(); #1 check("wrap_ff", retireCount, 32'hffff_ffff);
    instruction = 32'h0000_0020; cycle();
    idle(); #1 check("wrap_0", retireCount, 32'h0);

    // Reset priority: write and retire discarded, bypass suppressed
    wr(5'd12, 2'b00, 32'h55); cycle();
    wr(5'd12, 2'b00, 32'habcd); instruction = 32'h0000_0020; readReg1 = 5'd12; rst = 1'b1;
    #1 check("rstpri_nobyp", readData1, 32'h55);
    cycle();
    rst = 1'b0; idle(); dbgReg = 5'd12;
    #1 check("rstpri_reg", dbgData, 32'h0); check("rstpri_cnt", retireCount, 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 49) == 0);
      regWrite     = $urandom_range(0, 3) != 0;
      memToReg     = 2'($urandom_range(0, 3));
      writeDataReg = 5'($urandom_range(0, 31));
      aluResult    = $urandom;
      readData     = $urandom;
      fourPC       = 30'($urandom);
      instruction  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      readReg1     = ($urandom_range(0, 2) == 0) ? writeDataReg : 5'($urandom_range(0, 31));
      readReg2     = ($urandom_range(0, 2) == 0) ? writeDataReg : 5'($urandom_range(0, 31));
      dbgReg       = ($urandom_range(0, 2) == 0) ? writeDataReg : 5'($urandom_range(0, 31));
      cycle();
    end
    rst = 1'b0; idle();
    for (int r = 0; r < 32; r++) begin
      dbgReg = 5'(r);
      #1 check("final_dbg", dbgData, m_regs[r]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
